// File: rtl/noc_local_inject_arbiter.sv
// noc_local_inject_arbiter
//   Shares the router local input port among NumReq on-tile injectors. Arbitration
//   is round-robin per packet. The head flit of the winner locks the port to that
//   requester until its tail flit passes. There is one registered output stage, and
//   flow control uses the NoC void/stop convention.
//
// Ports
//   clk           clock
//   rst           asynchronous active-low reset
//   req_data      requester flits, requester i at [i*Width +: Width]
//   req_void      1: requester i has no flit
//   req_stop      1: requester i must hold its flit, 0: flit taken this cycle
//   data_out      flit to the router local input
//   data_void_out 1: data_out is empty
//   stop_in       router backpressure
//   grant_id      current or last owner
//   locked        a packet is in progress
//   proto_err     sticky protocol-error flag (cleared by reset only)
module noc_local_inject_arbiter #(
   parameter int unsigned NumReq = 4,
   parameter int unsigned Width  = 66
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NumReq*Width-1:0]   req_data,
   input  logic [NumReq-1:0]         req_void,
   output logic [NumReq-1:0]         req_stop,
   output logic [Width-1:0]          data_out,
   output logic                      data_void_out,
   input  logic                      stop_in,
   output logic [$clog2(NumReq)-1:0] grant_id,
   output logic                      locked,
   output logic                      proto_err
);

   localparam int unsigned    IdW    = $clog2(NumReq);
   localparam logic [IdW-1:0] LastId = IdW'(NumReq - 1);
   localparam logic [IdW:0]   NumW   = (IdW+1)'(NumReq);

   localparam logic [0:0] StIdle   = 1'b0;
   localparam logic [0:0] StLocked = 1'b1;

   logic [0:0]       state_q;
   logic [IdW-1:0]   rr_ptr_q;
   logic [IdW-1:0]   grant_q;
   logic [Width-1:0] data_q;
   logic             void_q;
   logic             err_q;

   logic [Width-1:0] flit [NumReq];
   logic [NumReq-1:0] head;
   logic [NumReq-1:0] tail;

   for (genvar i = 0; i < NumReq; i++) begin : g_split
      assign flit[i] = req_data[i*Width +: Width];
      assign head[i] = flit[i][Width-1];
      assign tail[i] = flit[i][Width-2];
   end

   logic             win_found;
   logic [IdW-1:0]   win_id;
   logic [IdW:0]     pos;
   logic             sel_valid;
   logic [IdW-1:0]   sel_id;
   logic [Width-1:0] sel_flit;
   logic             slot_free;
   logic             accept;
   logic             bad_idle;

   function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
      return (id == LastId) ? '0 : id + 1'b1;
   endfunction

   // Scan rr_ptr, rr_ptr+1, ... modulo NumReq. The extra bit in pos keeps the sum
   // exact for NumReq values that are not powers of two.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      pos       = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         pos = {1'b0, rr_ptr_q} + (IdW+1)'(k);
         if (pos >= NumW) pos = pos - NumW;
         if (!win_found && !req_void[pos[IdW-1:0]] && head[pos[IdW-1:0]]) begin
            win_found = 1'b1;
            win_id    = pos[IdW-1:0];
         end
      end
   end

   always_comb begin
      sel_id    = (state_q == StLocked) ? grant_q : win_id;
      sel_valid = (state_q == StLocked) ? ~req_void[grant_q] : win_found;
      sel_flit  = flit[sel_id];
      slot_free = void_q | ~stop_in;
      accept    = sel_valid & slot_free;
      // In IDLE, a requester that shows a flit without head is out of protocol.
      bad_idle  = (state_q == StIdle) && |(~req_void & ~head);
      req_stop  = '1;
      if (rst && accept) req_stop[sel_id] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         data_q   <= '0;
         void_q   <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            data_q <= sel_flit;
            void_q <= 1'b0;
         end else if (!void_q && !stop_in) begin
            void_q <= 1'b1;
         end

         if (bad_idle || (accept && state_q == StLocked && sel_flit[Width-1])) begin
            err_q <= 1'b1;
         end

         if (accept) begin
            if (state_q == StIdle) begin
               grant_q <= win_id;
               if (sel_flit[Width-2]) rr_ptr_q <= next_id(win_id);
               else                   state_q  <= StLocked;
            end else if (sel_flit[Width-2]) begin
               state_q  <= StIdle;
               rr_ptr_q <= next_id(grant_q);
            end
         end
      end
   end

   assign data_out      = data_q;
   assign data_void_out = void_q;
   assign grant_id      = grant_q;
   assign locked        = (state_q == StLocked);
   assign proto_err     = err_q;

endmodule

// File: doc/noc_local_inject_arbiter.md
Name: noc_local_inject_arbiter

Overview:
- Shares the router local input port (data_p_in, data_void_in[P], stop_out[P]) among NumReq on-tile injectors, for example the cache, DMA and interrupt sources.
- Arbitration is round-robin at packet granularity. Once a requester's head flit is granted, its port is locked until that requester's tail flit passes.
- The arbiter has one registered output stage and uses the NoC void/stop flow-control convention. It sits in the tile, between the injectors and the router wrapper.

Parameters:
- NumReq, 4, number of requesters (2..8).
- Width, 66, flit width including the preamble. Bit Width-1 is head and bit Width-2 is tail.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_data  in  NumReq*Width  flits; requester i occupies bits [i*Width +: Width].
- req_void  in  NumReq  1 means requester i has no flit.
- req_stop  out  NumReq  1 means requester i must hold its flit; 0 means the flit is taken this cycle.
- data_out  out  Width  flit to the router local input.
- data_void_out  out  1  1 means data_out is empty.
- stop_in  in  1  router backpressure on the local input.
- grant_id  out  $clog2(NumReq)  current or last owner.
- locked  out  1  a packet is in progress.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - data_void_out=1, data_out=0, state=IDLE, rr_ptr=0, grant_id=0, locked=0, proto_err=0.
  - req_stop is forced to all ones while rst=0.
- Output slot:
  - slot_free = data_void_out | ~stop_in.
  - The router consumes the output flit in any cycle with data_void_out=0 and stop_in=0.
  - On accept: data_out <= flit and data_void_out <= 0 at the next edge. Latency is 1 cycle.
  - Otherwise, if the flit is consumed: data_void_out <= 1.
  - Otherwise data_out and data_void_out hold.
  - A consume and a new accept in the same cycle give 1 flit/cycle.
  - stop_in has no effect while data_void_out=1.
- Accept rule: req_stop[i] is combinational and is 0 only for the single selected requester, and only when slot_free=1. Every other req_stop bit is 1.
- State IDLE:
  - Candidates are requesters with req_void=0 and head=1.
  - The winner is the first candidate found scanning rr_ptr, rr_ptr+1, and so on, modulo NumReq.
  - When the winner is accepted, grant_id <= winner.
  - If the flit has head=1 and tail=0, go to LOCKED (locked <= 1).
  - If the flit has head=1 and tail=1 (single-flit packet), stay IDLE and set rr_ptr <= winner+1 mod NumReq.
  - A requester presenting a non-head flit in IDLE is never selected; its req_stop stays 1 and proto_err <= 1.
  - With no candidates, or with slot_free=0, nothing is accepted and rr_ptr holds.
- State LOCKED:
  - Only requester grant_id is eligible. All other requesters see req_stop=1 even if slot_free=1.
  - Owner flit accepted with tail=1: go to IDLE, locked <= 0, rr_ptr <= grant_id+1 mod NumReq.
  - Owner flit with head=1 (nested head, missing tail): proto_err <= 1. The flit is forwarded and the state stays LOCKED unless tail=1.
  - Owner req_void=1 is a bubble: nothing is accepted and the lock is held indefinitely.
- proto_err is cleared only by reset.
- Reset mid-packet: the in-flight output flit is dropped (void), state returns to IDLE and rr_ptr returns to 0. Recovery of a partial packet is the requester's responsibility.
- rr_ptr arithmetic wraps from NumReq-1 to 0.
- Supporting NumReq values that are not powers of two is required.

Test Plan:
- Reset and idle:
  - Hold rst=0 for 3 cycles with all req_void=0 → req_stop=4'b1111, data_void_out=1.
  - Release rst with all req_void=1 → no output, rr_ptr stays 0.
- Round-robin with single-flit packets:
  - All 4 requesters continuously offer head+tail flits, stop_in=0.
  - Required: grant order 0,1,2,3,0; data_out carries the matching flit 1 cycle after each accept; data_void_out=0 every cycle after the first.
- Lock:
  - Req 1 sends head, body, body, tail while req 2 offers a head continuously.
  - Required: req_stop[2]=1 for all 4 cycles; locked=1 from the first edge until the tail edge; req 2 is granted in the cycle after the tail.
- Backpressure:
  - Set stop_in=1 for 5 cycles with data_void_out=0.
  - Required: data_out is stable; all req_stop=1; no flit is lost or duplicated; throughput resumes the cycle stop_in falls.
- Protocol error:
  - Req 3 presents a body flit (head=0) in IDLE → never accepted, proto_err=1, and proto_err stays 1 after valid traffic.
  - Owner sends a second head in LOCKED → proto_err=1 and the flit is still forwarded.
- Reset mid-packet:
  - Assert rst after req 0 head+body, while an output flit is pending.
  - Required: data_void_out=1 immediately (asynchronous); after release, state=IDLE and a new head from req 2 is granted first.
